// File: rtl/regfile_pkg.sv
// regfile_pkg: shared helpers and default widths for the multi-port register file.
//   aw(n)      address width for an n-entry file
//   reg_idx_t  register index at the default depth
//   xword_t    register word at the default width
//   ZERO_IDX   index of the hard-wired zero entry
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int aw(input int n);
    return $clog2(n);
  endfunction

  localparam int AW_DEF = aw(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

  localparam reg_idx_t ZERO_IDX = '0;

endpackage

// File: rtl/regfile_wr_sel.sv
// regfile_wr_sel: priority select of the write ports that target one address.
// Ports:
//   sel_addr  in   AW         address being matched
//   wr_en     in   NWR        write enables
//   wr_addr   in   NWR*AW     write addresses, port p at [p*AW +: AW]
//   wr_data   in   NWR*XLEN   write data, port p at [p*XLEN +: XLEN]
//   hit       out  1          some enabled port targets sel_addr
//   data      out  XLEN       data of the highest-index matching port
module regfile_wr_sel
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF,
  parameter int NWR  = 2
) (
  input  logic [AW-1:0]       sel_addr,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic                hit,
  output logic [XLEN-1:0]     data
);

  // Ascending scan: a later (higher-index) match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_addr[p*AW +: AW] == sel_addr)) begin
        hit  = 1'b1;
        data = wr_data[p*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register busy
// scoreboard for in-flight writebacks and a debug read tap.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and a cleared busy) to matching read ports.
// Ports:
//   clk       in   1          rising-edge clock
//   rst_n     in   1          async active-low reset
//   rd_addr   in   NRD*AW     read addresses, port p at [p*AW +: AW]
//   rd_data   out  NRD*XLEN   read data, port p at [p*XLEN +: XLEN]
//   rd_busy   out  NRD        addressed register has a pending writeback
//   wr_en     in   NWR        write enables (higher index wins)
//   wr_addr   in   NWR*AW     write addresses
//   wr_data   in   NWR*XLEN   write data
//   sb_set    in   1          mark sb_addr busy
//   sb_addr   in   AW         register to mark busy
//   dbg_addr  in   AW         debug tap address
//   dbg_data  out  XLEN       debug tap data, always the stored value
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN    = XLEN_DEF,
  parameter  int NREGS   = NREGS_DEF,
  parameter  int NRD     = 2,
  parameter  int NWR     = 2,
  parameter  int ZERO_R0 = 1,
  localparam int AW      = aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] busy;

  logic [NREGS-1:0] ent_hit;
  logic [XLEN-1:0]  ent_data [NREGS];
  logic [NREGS-1:0] wr_ok;
  logic [NREGS-1:0] set_ok;

  for (genvar e = 0; e < NREGS; e++) begin : g_ent
    // Entry 0 is hard-wired to zero: never written, never marked busy.
    localparam bit PROT = (ZERO_R0 != 0) && (e == 0);

    regfile_wr_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_sel (
      .sel_addr (AW'(e)),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .hit      (ent_hit[e]),
      .data     (ent_data[e])
    );

    assign wr_ok[e]  = ent_hit[e] && !PROT;
    assign set_ok[e] = sb_set && (sb_addr == AW'(e)) && !PROT;
  end

  // A new producer issued in the same cycle as the old one's writeback keeps
  // the register busy, so set takes precedence over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NREGS; e++) mem[e] <= '0;
      busy <= '0;
    end else begin
      for (int e = 0; e < NREGS; e++) begin
        if (wr_ok[e]) mem[e] <= ent_data[e];
        if (set_ok[e])     busy[e] <= 1'b1;
        else if (wr_ok[e]) busy[e] <= 1'b0;
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            r0_forced;
    logic [XLEN-1:0] pd;
    logic            pb;

    assign ra        = rd_addr[p*AW +: AW];
    assign r0_forced = (ZERO_R0 != 0) && (ra == '0);

`ifdef REGFILE_BYPASS_EN
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;

    regfile_wr_sel #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_byp (
      .sel_addr (ra),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .hit      (byp_hit),
      .data     (byp_data)
    );

    always_comb begin
      pd = mem[ra];
      pb = busy[ra];
      if (byp_hit) begin
        pd = byp_data;
        pb = 1'b0;
      end
      if (r0_forced) begin
        pd = '0;
        pb = 1'b0;
      end
    end
`else
    always_comb begin
      pd = mem[ra];
      pb = busy[ra];
      if (r0_forced) begin
        pd = '0;
        pb = 1'b0;
      end
    end
`endif

    assign rd_data[p*XLEN +: XLEN] = pd;
    assign rd_busy[p]              = pb;
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
`timescale 1ns/1ps
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW2  = 4;
  localparam int NRD2 = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;

  logic [NRD2*AW2-1:0]  rd_addr2;
  logic [NRD2*XLEN-1:0] rd_data2;
  logic [NRD2-1:0]      rd_busy2;
  logic [0:0]           wr2_en;
  logic [AW2-1:0]       wr2_addr;
  logic [XLEN-1:0]      wr2_data;
  logic                 sb2_set;
  logic [AW2-1:0]       sb2_addr;
  logic [AW2-1:0]       dbg2_addr;
  logic [XLEN-1:0]      dbg2_data;

  always #5 clk = ~clk;

  regfile_mp u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3), .NWR(1), .ZERO_R0(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
    .wr_en(wr2_en), .wr_addr(wr2_addr), .wr_data(wr2_data),
    .sb_set(sb2_set), .sb_addr(sb2_addr),
    .dbg_addr(dbg2_addr), .dbg_data(dbg2_data)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected values queued at stimulus time, compared when sampled.
  typedef struct {
    string       tag;
    int          src;
    logic [31:0] val;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [31:0] observe(input int src);
    case (src)
      0: return rd_data[0*XLEN +: XLEN];
      1: return rd_data[1*XLEN +: XLEN];
      2: return 32'(rd_busy[0]);
      3: return 32'(rd_busy[1]);
      4: return dbg_data;
      5: return rd_data2[0*XLEN +: XLEN];
      6: return rd_data2[1*XLEN +: XLEN];
      7: return rd_data2[2*XLEN +: XLEN];
      8: return 32'(rd_busy2);
      9: return dbg2_data;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int src, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.src = src;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, observe(e.src), e.val);
    end
  endtask

  // Reference model of the default-parameter instance.
  logic [31:0] m [32];
  logic        b [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m[i] = '0;
      b[i] = 1'b0;
    end
  endtask

  task automatic model_update();
    logic wrote [32];
    logic [4:0] a;
    for (int i = 0; i < 32; i++) wrote[i] = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      a = wr_addr[p*AW +: AW];
      if (wr_en[p] && a != 5'd0) begin
        m[a]     = wr_data[p*XLEN +: XLEN];
        wrote[a] = 1'b1;
      end
    end
    for (int i = 1; i < 32; i++) begin
      if (sb_set && sb_addr == 5'(i)) b[i] = 1'b1;
      else if (wrote[i])              b[i] = 1'b0;
    end
  endtask

  task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
    wr_en[port]              = 1'b1;
    wr_addr[port*AW +: AW]   = a;
    wr_data[port*XLEN +: XLEN] = d;
  endtask

  // Drive a read port and queue its expected data/busy from the model,
  // honouring same-cycle forwarding when built with bypass.
  task automatic rd(input string tag, input int port, input logic [4:0] a);
    logic [31:0] d;
    logic        bz;
    rd_addr[port*AW +: AW] = a;
    d  = m[a];
    bz = b[a];
    if (BYP && a != 5'd0) begin
      for (int q = 0; q < NWR; q++) begin
        if (wr_en[q] && wr_addr[q*AW +: AW] == a) begin
          d  = wr_data[q*XLEN +: XLEN];
          bz = 1'b0;
        end
      end
    end
    push_exp({tag, "_data"}, port, d);
    push_exp({tag, "_busy"}, 2 + port, 32'(bz));
  endtask

  task automatic dbg_rd(input string tag, input logic [4:0] a);
    dbg_addr = a;
    push_exp(tag, 4, m[a]);
  endtask

  task automatic idle();
    wr_en   = '0;
    sb_set  = 1'b0;
    wr2_en  = '0;
  endtask

  task automatic step();
    @(negedge clk);
    drain();
    model_update();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    rst_n    = 1'b0;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    sb_set   = 1'b0;
    sb_addr  = '0;
    dbg_addr = '0;
    rd_addr2 = '0;
    wr2_en   = '0;
    wr2_addr = '0;
    wr2_data = '0;
    sb2_set  = 1'b0;
    sb2_addr = '0;
    dbg2_addr = '0;
    model_reset();

    // Reset state.
    #2;
    rd("rst_r5", 0, 5'd5);
    rd("rst_r31", 1, 5'd31);
    dbg_rd("rst_dbg", 5'd0);
    @(negedge clk);
    drain();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load entries 1..31 with index*3, two per cycle.
    for (int i = 1; i < 32; i += 2) begin
      wr(0, 5'(i), 32'(i * 3));
      if (i + 1 < 32) wr(1, 5'(i + 1), 32'((i + 1) * 3));
      step();
    end
    sb_set  = 1'b1;
    sb_addr = 5'd4;
    step();

    // Loaded values, then async reset in the middle of a cycle with a
    // write pending: outputs drop immediately and the write is lost.
    rd("load_r31", 0, 5'd31);
    rd("load_r4", 1, 5'd4);
    dbg_rd("load_dbg10", 5'd10);
    wr(0, 5'd6, 32'h66);
    @(negedge clk);
    drain();
    #2 rst_n = 1'b0;
    model_reset();
    rd("async_r31", 0, 5'd31);
    rd("async_r4", 1, 5'd4);
    dbg_rd("async_dbg10", 5'd10);
    #1 drain();
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    #2 rst_n = 1'b1;
    rd("lost_r6", 0, 5'd6);
    #1 drain();
    @(posedge clk);
    #1;

    // Write then read; r0 is hard-wired.
    wr(0, 5'd5, 32'h0000_0005);
    rd("wr_r5_same", 0, 5'd5);
    step();
    rd("wr_r5_next", 0, 5'd5);
    step();
    wr(0, 5'd0, 32'hDEAD_BEEF);
    rd("wr_r0_same", 1, 5'd0);
    step();
    rd("wr_r0_next", 1, 5'd0);
    step();

    // Same-address collision: higher port wins.
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    step();
    rd("coll_r7", 0, 5'd7);
    step();

    // Scoreboard set / clear / set-wins.
    sb_set = 1'b1; sb_addr = 5'd9;
    rd("sb_r9_pre", 1, 5'd9);
    step();
    rd("sb_r9_set", 1, 5'd9);
    step();
    wr(0, 5'd9, 32'h44);
    rd("sb_r9_wr", 1, 5'd9);
    step();
    rd("sb_r9_clr", 1, 5'd9);
    step();
    sb_set = 1'b1; sb_addr = 5'd9;
    wr(1, 5'd9, 32'h44);
    step();
    rd("sb_r9_setwins", 1, 5'd9);
    sb_set = 1'b1; sb_addr = 5'd0;
    step();
    rd("sb_r0_ign", 0, 5'd0);
    step();

    // Forwarding (or not) of a same-cycle write.
    sb_set = 1'b1; sb_addr = 5'd3;
    step();
    wr(0, 5'd3, 32'h0000_CAFE);
    rd("byp_r3_same", 1, 5'd3);
    step();
    rd("byp_r3_next", 1, 5'd3);
    step();

    // Random traffic with frequent address collisions.
    for (int k = 0; k < 60; k++) begin
      for (int p = 0; p < NWR; p++)
        if ($urandom_range(1, 0) == 1) wr(p, 5'($urandom_range(7, 0)), $urandom);
      if ($urandom_range(2, 0) == 0) begin
        sb_set  = 1'b1;
        sb_addr = 5'($urandom_range(7, 0));
      end
      rd("rnd_p0", 0, 5'($urandom_range(7, 0)));
      rd("rnd_p1", 1, 5'($urandom_range(7, 0)));
      dbg_rd("rnd_dbg", 5'($urandom_range(7, 0)));
      step();
    end

    // Alternate parameters: 16 entries, 3 read ports, 1 write port, writable r0.
    wr2_en = 1'b1; wr2_addr = '0; wr2_data = 32'h1234;
    step();
    wr2_en = 1'b1; wr2_addr = 4'(21); wr2_data = 32'hABCD;
    step();
    rd_addr2 = {4'd15, 4'd5, 4'd0};
    dbg2_addr = 4'd5;
    push_exp("p2_r0", 5, 32'h1234);
    push_exp("p2_r5_wrap", 6, 32'hABCD);
    push_exp("p2_r15", 7, 32'h0);
    push_exp("p2_busy", 8, 32'h0);
    push_exp("p2_dbg5", 9, 32'hABCD);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
